// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - switch/button inputs and operand/result outputs of the ALU sequencer
interface alu_seq_ctrl_if;
    logic [3:0] SW;
    logic       ENTER;
    logic       SUB;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] R;
    logic       ovf;
    logic [1:0] STATE;
    logic       R_VALID;

    modport master (
        output SW, ENTER, SUB,
        input  A, B, R, ovf, STATE, R_VALID
    );

    modport slave (
        input  SW, ENTER, SUB,
        output A, B, R, ovf, STATE, R_VALID
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - debounced ENTER sequencer for 4-bit add/subtract operand entry
module alu_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic          CLOCK_50,
    input logic          RST,
    alu_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            sync1;
    logic            enter_s;
    logic [CW-1:0]   run_cnt;
    logic            run_full;
    logic            armed;
    logic            accept;
    logic [3:0]      a_q;
    logic [3:0]      b_q;
    logic [3:0]      r_q;
    logic            ovf_q;
    logic [3:0]      b_x;
    logic [3:0]      sum;
    logic            ovf_next;
    logic            r_valid;

    assign run_full = (run_cnt == CNT_MAX);

    // run_cnt counts the current cycle, so it restarts at 1 whenever enter_s is about to flip
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            sync1   <= 1'b0;
            enter_s <= 1'b0;
            run_cnt <= '0;
            armed   <= 1'b0;
            accept  <= 1'b0;
        end else begin
            sync1   <= bus.ENTER;
            enter_s <= sync1;
            if (sync1 != enter_s)
                run_cnt <= CW'(1);
            else if (!run_full)
                run_cnt <= run_cnt + CW'(1);
            accept <= armed && enter_s && run_full;
            if (armed && enter_s && run_full)
                armed <= 1'b0;
            else if (!enter_s && run_full)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST)
            state <= LOAD_A;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_A:  if (accept) state_next = LOAD_B;
            LOAD_B:  if (accept) state_next = EXEC;
            EXEC:    state_next = SHOW;
            SHOW:    if (accept) state_next = LOAD_B;
            default: state_next = LOAD_A;
        endcase
    end

    always_comb begin
        r_valid = (state == SHOW);
    end

    // Subtraction reuses the adder: invert B and inject SUB as carry-in
    assign b_x      = b_q ^ {4{bus.SUB}};
    assign sum      = a_q + b_x + {3'b000, bus.SUB};
    assign ovf_next = (a_q[3] == b_x[3]) && (sum[3] != a_q[3]);

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            a_q   <= 4'b0000;
            b_q   <= 4'b0000;
            r_q   <= 4'b0000;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (accept) a_q <= bus.SW;
                LOAD_B: if (accept) b_q <= bus.SW;
                EXEC: begin
                    r_q   <= sum;
                    ovf_q <= ovf_next;
                end
                SHOW: if (accept) begin
                    a_q   <= bus.SW;
                    r_q   <= 4'b0000;
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.R       = r_q;
    assign bus.ovf     = ovf_q;
    assign bus.STATE   = state;
    assign bus.R_VALID = r_valid;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed, table-driven bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   exec_seen;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial exec_seen = 0;
    always @(negedge clk) if (bus.STATE == 2'b10) exec_seen <= exec_seen + 1;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] sw, input logic sub);
        bus.SW    = sw;
        bus.SUB   = sub;
        bus.ENTER = 1'b1;
        cycles(8);
        bus.ENTER = 1'b0;
        cycles(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},   int'(bus.STATE), 0);
        check({tag, "_a"},       int'(bus.A), 0);
        check({tag, "_b"},       int'(bus.B), 0);
        check({tag, "_r"},       int'(bus.R), 0);
        check({tag, "_ovf"},     int'(bus.ovf), 0);
        check({tag, "_rvalid"},  int'(bus.R_VALID), 0);
    endtask

    initial begin
        int e0;
        tests  = 0;
        failed = 0;

        vecs[0] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1};
        vecs[1] = '{4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b1};
        vecs[2] = '{4'b1111, 4'b1000, 1'b1, 4'b0111, 1'b0};
        vecs[3] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1};
        vecs[4] = '{4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0};
        vecs[5] = '{4'b1001, 4'b1010, 1'b0, 4'b0011, 1'b1};

        // Reset with the button held through it
        bus.SW = 4'b0000; bus.SUB = 1'b0; bus.ENTER = 1'b1;
        rst = 1'b1;
        cycles(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        cycles(20);
        check("held_state", int'(bus.STATE), 0);
        check("held_a", int'(bus.A), 0);
        bus.ENTER = 1'b0;
        cycles(8);
        press(4'b0011, 1'b0);
        check("first_a", int'(bus.A), 3);
        check("first_state", int'(bus.STATE), 1);

        // Plain add
        e0 = exec_seen;
        press(4'b0010, 1'b0);
        check("add_r", int'(bus.R), 5);
        check("add_ovf", int'(bus.ovf), 0);
        check("add_state", int'(bus.STATE), 3);
        check("add_rvalid", int'(bus.R_VALID), 1);
        check("add_exec_cycles", exec_seen - e0, 1);

        // SHOW ignores SW/SUB changes
        for (int i = 0; i < 50; i++) begin
            bus.SW  = 4'(i);
            bus.SUB = i[0];
            cycles(1);
        end
        check("show_hold_r", int'(bus.R), 5);
        check("show_hold_ovf", int'(bus.ovf), 0);
        press(4'b1010, 1'b0);
        check("chain_a", int'(bus.A), 10);
        check("chain_r", int'(bus.R), 0);
        check("chain_ovf", int'(bus.ovf), 0);
        check("chain_rvalid", int'(bus.R_VALID), 0);
        check("chain_state", int'(bus.STATE), 1);
        press(4'b0000, 1'b0);
        check("chain_add_r", int'(bus.R), 10);
        check("chain_add_ovf", int'(bus.ovf), 0);

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].a, 1'b0);
            check($sformatf("vec%0d_a", i), int'(bus.A), int'(vecs[i].a));
            press(vecs[i].b, vecs[i].sub);
            check($sformatf("vec%0d_r", i), int'(bus.R), int'(vecs[i].r));
            check($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(vecs[i].ovf));
            check($sformatf("vec%0d_state", i), int'(bus.STATE), 3);
        end

        // Debounce: short glitches, then an exactly-timed press
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(10);
        for (int w = 1; w <= 3; w++) begin
            bus.ENTER = 1'b1;
            cycles(w);
            bus.ENTER = 1'b0;
            cycles(8);
            check($sformatf("glitch%0d_state", w), int'(bus.STATE), 0);
        end
        bus.SW = 4'b0110;
        bus.ENTER = 1'b1;
        cycles(6);
        check("deb_edge_k5", int'(bus.STATE), 0);
        cycles(1);
        check("deb_edge_k6", int'(bus.STATE), 1);
        check("deb_a", int'(bus.A), 6);
        cycles(100);
        check("deb_hold_state", int'(bus.STATE), 1);
        bus.ENTER = 1'b0;
        cycles(8);

        // Reset in LOAD_B
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_reset_outputs("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
